// File: rtl/mem_req_unit_if.sv
// Bundle of the pipeline-side request/response handshake and the mem_system bus.
//   req_*      : pipeline -> unit request (valid/ready)
//   resp_*     : unit -> pipeline completion (one-cycle valid pulse, sticky data)
//   stall_pipe : unit busy indicator
//   mem_*      : unit <-> mem_system (Addr/DataIn/Rd/Wr out, DataOut/Done/CacheHit/err in)
// Modport slave is the unit's view; master is the environment (pipeline + memory).
interface mem_req_unit_if;
  logic        req_valid;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;

  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_hit;
  logic        resp_err;
  logic        stall_pipe;

  logic [15:0] mem_Addr;
  logic [15:0] mem_DataIn;
  logic        mem_Rd;
  logic        mem_Wr;
  logic [15:0] mem_DataOut;
  logic        mem_Done;
  logic        mem_CacheHit;
  logic        mem_err;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_hit, resp_err, stall_pipe,
    output mem_Addr, mem_DataIn, mem_Rd, mem_Wr,
    input  mem_DataOut, mem_Done, mem_CacheHit, mem_err
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_hit, resp_err, stall_pipe,
    input  mem_Addr, mem_DataIn, mem_Rd, mem_Wr,
    output mem_DataOut, mem_Done, mem_CacheHit, mem_err
  );
endinterface

// File: rtl/mem_req_unit.sv
// Pipeline-side initiator for mem_system. Accepts one load/store at a time, drives the
// memory bus with registered, stable Addr/DataIn/Rd/Wr until Done (or error/timeout),
// then returns a one-cycle response pulse with read data, hit and error status.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   bus          : request/response handshake and mem_system bus (see mem_req_unit_if)
//   timeout_flag : sticky, set on any timeout, cleared only by reset
//   access_cnt   : saturating count of error-free completions
//   hit_cnt      : saturating count of completions reported as cache hit
module mem_req_unit #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_unit_if.slave    bus,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] access_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_hit_q, resp_hit_d;
  logic             resp_err_q, resp_err_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] access_q, access_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_hit_d   = resp_hit_q;
    resp_err_d   = resp_err_q;
    timeout_d    = timeout_q;
    access_d     = access_q;
    hit_d        = hit_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_addr[0]) begin
            // Misaligned: nothing reaches memory, answer directly with an error.
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_hit_d   = 1'b0;
            resp_rdata_d = 16'h0000;
          end else begin
            state_d = StWait;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            rd_d    = ~bus.req_wr;
            wr_d    = bus.req_wr;
            tcnt_d  = '0;
          end
        end
      end

      StWait: begin
        tcnt_d = tcnt_q + 1'b1;
        // Priority: Done, then error without Done, then timeout.
        if (bus.mem_Done || bus.mem_err || (tcnt_q == TLast)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          if (bus.mem_Done) begin
            resp_err_d   = bus.mem_err;
            resp_hit_d   = bus.mem_CacheHit & ~bus.mem_err;
            resp_rdata_d = (rd_q && !bus.mem_err) ? bus.mem_DataOut : 16'h0000;
          end else begin
            resp_err_d   = 1'b1;
            resp_hit_d   = 1'b0;
            resp_rdata_d = 16'h0000;
            if (!bus.mem_err) begin
              timeout_d = 1'b1;
            end
          end
        end
      end

      StResp: begin
        state_d = StIdle;
        if (!resp_err_q && (access_q != CntMax)) begin
          access_d = access_q + 1'b1;
        end
        if (resp_hit_q && (hit_q != CntMax)) begin
          hit_d = hit_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      tcnt_q       <= '0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
      access_q     <= '0;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      resp_err_q   <= resp_err_d;
      timeout_q    <= timeout_d;
      access_q     <= access_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.stall_pipe = (state_q != StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_Addr   = addr_q;
  assign bus.mem_DataIn = wdata_q;
  assign bus.mem_Rd     = rd_q;
  assign bus.mem_Wr     = wr_q;
  assign timeout_flag   = timeout_q;
  assign access_cnt     = access_q;
  assign hit_cnt        = hit_q;

endmodule
